// File: rtl/gain_multiplier.sv
// Sign-magnitude shift-add gain multiplier.
// Scales a direct-code operand by a fixed-point gain in WIDTH clocks.
module gain_multiplier #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int MSB   = WIDTH - 1
) (
  input  logic             clk_i,
  input  logic             nReset_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] gain_i,
  output logic [WIDTH-1:0] out_o,
  output logic             overflow_o,
  output logic             finish_o
);

  localparam int MW = WIDTH - 1;
  localparam int AW = 2 * MW;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);
  localparam logic [AW-1:0] MAXM = AW'({MW{1'b1}});

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [AW-1:0]    opd_q, opd_d;
  logic [MW-1:0]    gain_q, gain_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             fin_q, fin_d;

  logic [AW-1:0]    scaled;
  logic             sat;
  logic [MW-1:0]    mag;

  // Final scaling: truncate fraction, saturate, suppress negative zero.
  always_comb begin
    scaled = acc_q >> FRAC;
    sat    = scaled > MAXM;
    mag    = sat ? MAXM[MW-1:0] : scaled[MW-1:0];
  end

  // State register plus datapath registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!nReset_i) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      opd_q   <= '0;
      gain_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      fin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      opd_q   <= opd_d;
      gain_q  <= gain_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      fin_q   <= fin_d;
    end
  end

  // Next-state logic: WIDTH-1 multiply steps then one final step.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = enable_i ? MUL : IDLE;
      MUL:     state_d = (cnt_q == LAST) ? FINAL : MUL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output next values; operand shifts left, gain shifts right.
  always_comb begin
    sign_d = sign_q;
    opd_d  = opd_q;
    gain_d = gain_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    ovf_d  = ovf_q;
    fin_d  = fin_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          sign_d = in_i[MSB] ^ gain_i[MSB];
          opd_d  = AW'(in_i[MSB-1:0]);
          gain_d = gain_i[MSB-1:0];
          acc_d  = '0;
          cnt_d  = '0;
          out_d  = '0;
          ovf_d  = 1'b0;
          fin_d  = 1'b0;
        end
      end
      MUL: begin
        acc_d  = acc_q + (gain_q[0] ? opd_q : '0);
        opd_d  = opd_q << 1;
        gain_d = gain_q >> 1;
        cnt_d  = cnt_q + 1'b1;
      end
      FINAL: begin
        out_d = {sign_q & (mag != '0), mag};
        ovf_d = sat;
        fin_d = 1'b1;
      end
      default: begin
        fin_d = 1'b1;
      end
    endcase
  end

  assign out_o      = out_q;
  assign overflow_o = ovf_q;
  assign finish_o   = fin_q;

endmodule

// File: tb/tb_gain_multiplier.sv
// Self-checking bench for gain_multiplier.
// Directed spec cases plus randomized ops against an arithmetic model.
module tb_gain_multiplier;

  localparam int W = 16;
  localparam int F = 8;

  logic         clk;
  logic         nReset;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] g;
  logic [W-1:0] out;
  logic         ovf;
  logic         fin;

  int n_chk = 0;
  int n_fail = 0;

  gain_multiplier #(.WIDTH(W), .FRAC(F)) dut (
    .clk_i      (clk),
    .nReset_i   (nReset),
    .enable_i   (en),
    .in_i       (a),
    .gain_i     (g),
    .out_o      (out),
    .overflow_o (ovf),
    .finish_o   (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on sign and magnitude.
  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] k);
    longint unsigned p, s, maxm;
    logic [W-2:0] m;
    logic sg, o;
    maxm = (longint'(1) << (W - 1)) - 1;
    p  = longint'(x[W-2:0]) * longint'(k[W-2:0]);
    s  = p >> F;
    o  = s > maxm;
    m  = o ? (W-1)'(maxm) : (W-1)'(s);
    sg = (x[W-1] ^ k[W-1]) && (m != 0);
    return {o, sg, m};
  endfunction

  // Issue one op and wait for finish; lat = edges after accept, -1 on timeout.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] k,
                        output int lat);
    en = 1'b1; a = x; g = k;
    step();
    en = 1'b0;
    a = W'($urandom); g = W'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (fin) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] o0;
    nReset = 1'b0; en = 1'b0; a = '0; g = '0;
    step(); step();
    nReset = 1'b1;
    n_chk++;
    if (out !== 16'h0000 || ovf !== 1'b0 || fin !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: out=%h ovf=%b fin=%b want 0000 0 1",
               out, ovf, fin);
    end
    o0 = out;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); g = W'($urandom);
      step();
      n_chk++;
      if (out !== 16'h0000 || ovf !== 1'b0 || fin !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_hold c%0d: out=%h ovf=%b fin=%b want 0000 0 1",
                 i, out, ovf, fin);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ti [14] = '{16'h0064, 16'h8064, 16'h0064, 16'h8064,
                              16'h0003, 16'h8003, 16'h8001, 16'h8000,
                              16'h7FFF, 16'hC000, 16'h0010,
                              16'h0000, 16'h0001, 16'h7FFF};
    logic [W-1:0] tg [14] = '{16'h0180, 16'h0180, 16'h8180, 16'h8180,
                              16'h0080, 16'h0080, 16'h0040, 16'h0100,
                              16'h0200, 16'h0200, 16'h0100,
                              16'hFFFF, 16'h0100, 16'h0100};
    logic [W-1:0] to [14] = '{16'h0096, 16'h8096, 16'h8096, 16'h0096,
                              16'h0001, 16'h8001, 16'h0000, 16'h0000,
                              16'h7FFF, 16'hFFFF, 16'h0010,
                              16'h0000, 16'h0001, 16'h7FFF};
    logic         tv [14] = '{1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 14; i++) begin
      run_op(ti[i], tg[i], lat);
      n_chk++;
      if (lat != 16 || out !== to[i] || ovf !== tv[i]) begin
        n_fail++;
        $display("FAIL directed%0d %h*%h: out=%h ovf=%b lat=%0d want %h %b 16",
                 i, ti[i], tg[i], out, ovf, lat, to[i], tv[i]);
      end
    end
  endtask

  task automatic test_ovf_clear();
    int lat;
    run_op(16'h7FFF, 16'h0200, lat);
    en = 1'b1; a = 16'h0010; g = 16'h0100;
    step();
    en = 1'b0;
    n_chk++;
    if (ovf !== 1'b0 || fin !== 1'b0 || out !== 16'h0000) begin
      n_fail++;
      $display("FAIL ovf_clear_accept: ovf=%b fin=%b out=%h want 0 0 0000",
               ovf, fin, out);
    end
    for (int i = 0; i < 20 && !fin; i++) step();
    n_chk++;
    if (out !== 16'h0010 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear_result: out=%h ovf=%b want 0010 0", out, ovf);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, k;
    logic [W:0] e;
    int lat;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      k = W'($urandom);
      if (i % 5 == 0) k[W-2:0] = (W-1)'($urandom_range(0, 1023));
      if (i % 7 == 0) x[W-2:0] = '0;
      e = model(x, k);
      run_op(x, k, lat);
      n_chk++;
      if (lat != 16 || out !== e[W-1:0] || ovf !== e[W]) begin
        n_fail++;
        $display("FAIL random%0d %h*%h: out=%h ovf=%b lat=%0d want %h %b 16",
                 i, x, k, out, ovf, lat, e[W-1:0], e[W]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W:0] e;
    en = 1'b1; a = 16'h0064; g = 16'h0180;
    step();
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      en = 1'($urandom);
      a = W'($urandom); g = W'($urandom);
      if (i > 16) en = 1'b0;
      step();
      if (fin) begin
        lat = i;
        break;
      end
    end
    n_chk++;
    if (lat != 16 || out !== 16'h0096 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_enable: out=%h ovf=%b lat=%0d want 0096 0 16",
               out, ovf, lat);
    end
    e = model(16'h0002, 16'h0300);
    run_op(16'h0002, 16'h0300, lat);
    n_chk++;
    if (lat != 16 || out !== 16'h0006 || out !== e[W-1:0]) begin
      n_fail++;
      $display("FAIL back_to_back: out=%h lat=%0d want 0006 16", out, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    en = 1'b1; a = 16'h0064; g = 16'h0180;
    step();
    en = 1'b0;
    for (int i = 1; i < 8; i++) step();
    nReset = 1'b0;
    step();
    nReset = 1'b1;
    n_chk++;
    if (out !== 16'h0000 || fin !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: out=%h fin=%b ovf=%b want 0000 1 0",
               out, fin, ovf);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_chk++;
      if (out !== 16'h0000 || fin !== 1'b1) begin
        n_fail++;
        $display("FAIL no_late_result c%0d: out=%h fin=%b want 0000 1",
                 i, out, fin);
      end
    end
    run_op(16'h0064, 16'h0180, lat);
    n_chk++;
    if (lat != 16 || out !== 16'h0096 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_op: out=%h ovf=%b lat=%0d want 0096 0 16",
               out, ovf, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ovf_clear();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
